// File: rtl/ft1248_pkg.sv
// Shared FT1248 definitions.
//   e_cmd    : command bytes issued by the FPGA-side USB master
//   e_state  : responder protocol phases
//   BUS_IDLE : value the responder presents when it is not driving data
//   cmd_ack  : decides whether a command byte is accepted at the command tick
package ft1248_pkg;

    typedef enum logic [7:0] {
        CMD_WRITE    = 8'h00,
        CMD_READ     = 8'h40,
        CMD_MODEM_RD = 8'h20,
        CMD_MODEM_WR = 8'h60,
        CMD_FLUSH    = 8'h08
    } e_cmd;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COMMAND,
        ST_STATUS,
        ST_DATA,
        ST_DONE
    } e_state;

    localparam logic [7:0] BUS_IDLE = 8'hFF;

    // rx_space: a byte can be pushed toward the consumer.
    // tx_data : at least one byte is (or is becoming) available for the master.
    function automatic logic cmd_ack(input logic [7:0] cmd, input logic rx_space,
                                     input logic tx_data);
        logic ack;
        ack = 1'b0;
        case (cmd)
            CMD_WRITE:                          ack = rx_space;
            CMD_READ:                           ack = tx_data;
            CMD_MODEM_RD, CMD_MODEM_WR, CMD_FLUSH: ack = 1'b1;
            default:                            ack = 1'b0;
        endcase
        return ack;
    endfunction

endpackage

// File: rtl/ft1248_responder_fifo.sv
// First-word-fall-through byte FIFO, FIFO_DEPTH entries.
//   wr_valid/wr_ready/wr_data : push side (wr_ready = not full)
//   rd_valid/rd_ready/rd_data : pop side  (rd_valid = not empty)
//   look_ahead                : when set, rd_data shows the head that will be
//                               current after this cycle's pop (honouring a
//                               same-cycle push into a single-entry FIFO)
//   count                     : current occupancy
module ft1248_responder_fifo
    import ft1248_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [7:0]                    wr_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    input  logic                          look_ahead,
    output logic [7:0]                    rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_nxt;
    logic          push;
    logic          pop;

    assign wr_ready   = (count != CW'(FIFO_DEPTH));
    assign rd_valid   = (count != '0);
    assign push       = wr_valid && wr_ready;
    assign pop        = rd_ready && rd_valid;
    assign rd_ptr_nxt = rd_ptr + AW'(1);

    always_comb begin
        rd_data = mem[rd_ptr];
        if (look_ahead) begin
            // With one entry left the next head can only be the byte arriving now.
            rd_data = (count >= CW'(2)) ? mem[rd_ptr_nxt] : wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr_nxt;
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ft1248_responder.sv
// FT1248 device-side responder: answers the USB master's write, read, modem
// status read/write and flush commands.
//   clk, reset                         : system clock, synchronous active-high reset
//   ft_clk, ft_cs, ft_miosi_in         : master-driven link pins (asynchronous)
//   ft_miso, ft_miosi_out, ft_miosi_oe : responder-driven link pins (registered)
//   ft_pwrsav                          : registered !suspend
//   rx_valid/rx_data/rx_ready          : bytes written by the master
//   tx_valid/tx_data/tx_ready          : bytes the master will read
//   modem_status_in/out/write          : modem status byte in both directions
//   flush                              : pulse on an acked flush command
//   busy                               : synchronized chip select is low
module ft1248_responder
    import ft1248_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ft_clk,
    input  logic       ft_cs,
    output logic       ft_miso,
    input  logic [7:0] ft_miosi_in,
    output logic [7:0] ft_miosi_out,
    output logic       ft_miosi_oe,
    output logic       ft_pwrsav,
    input  logic       suspend,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       rx_ready,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic [7:0] modem_status_in,
    output logic [7:0] modem_status_out,
    output logic       modem_status_write,
    output logic       flush,
    output logic       busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [7:0]             miosi_sync [SYNC_STAGES];
    logic                   clk_s_d;
    logic                   cs_s_d;
    logic                   tick_p1;
    logic [7:0]             miosi_p1;
    logic                   cs_s;

    e_state     state;
    logic [7:0] cmd;

    logic          rx_push;
    logic          rx_space;
    logic [CW-1:0] rx_count;
    logic          rx_local_pop;
    logic          rx_full_after;
    logic          tx_pop;
    logic          tx_avail;
    logic [7:0]    tx_head;
    logic [CW-1:0] tx_count;
    logic          tx_local_push;
    logic          tx_more;

    assign cs_s = cs_sync[SYNC_STAGES-1];

    // Stage p0: synchronizers (data path, not reset; reset is held long enough to flush them)
    always_ff @(posedge clk) begin
        clk_sync[0]   <= ft_clk;
        cs_sync[0]    <= ft_cs;
        miosi_sync[0] <= ft_miosi_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            clk_sync[i]   <= clk_sync[i-1];
            cs_sync[i]    <= cs_sync[i-1];
            miosi_sync[i] <= miosi_sync[i-1];
        end
        clk_s_d <= clk_sync[SYNC_STAGES-1];
        cs_s_d  <= cs_s;
    end

    // Stage p1: registered tick with the bus byte captured at the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_p1 <= 1'b0;
        end else begin
            tick_p1 <= clk_sync[SYNC_STAGES-1] && !clk_s_d;
        end
        miosi_p1 <= miosi_sync[SYNC_STAGES-1];
    end

    // FIFO state as seen in the tick cycle, including the local side's activity.
    assign rx_local_pop  = rx_ready && rx_valid;
    assign tx_local_push = tx_valid && tx_ready;
    assign rx_full_after = (int'(rx_count) + 1 - int'(rx_local_pop)) == FIFO_DEPTH;
    assign tx_more       = (int'(tx_count) + int'(tx_local_push)) > 1;

    assign rx_push = !cs_s && tick_p1 && (state == ST_DATA) && !ft_miso && (cmd == CMD_WRITE);
    assign tx_pop  = !cs_s && tick_p1 && (state == ST_DATA) && !ft_miso && (cmd == CMD_READ);

    ft1248_responder_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk        (clk),
        .reset      (reset),
        .wr_valid   (rx_push),
        .wr_ready   (rx_space),
        .wr_data    (miosi_p1),
        .rd_valid   (rx_valid),
        .rd_ready   (rx_ready),
        .look_ahead (1'b0),
        .rd_data    (rx_data),
        .count      (rx_count)
    );

    ft1248_responder_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk        (clk),
        .reset      (reset),
        .wr_valid   (tx_valid),
        .wr_ready   (tx_ready),
        .wr_data    (tx_data),
        .rd_valid   (tx_avail),
        .rd_ready   (tx_pop),
        .look_ahead (tx_pop),
        .rd_data    (tx_head),
        .count      (tx_count)
    );

    // Stage p2: protocol FSM with registered link outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= ST_IDLE;
            cmd                <= 8'h00;
            ft_miso            <= 1'b1;
            ft_miosi_out       <= BUS_IDLE;
            ft_miosi_oe        <= 1'b0;
            ft_pwrsav          <= 1'b1;
            modem_status_out   <= 8'h00;
            modem_status_write <= 1'b0;
            flush              <= 1'b0;
            busy               <= 1'b0;
        end else begin
            flush              <= 1'b0;
            modem_status_write <= 1'b0;
            busy               <= !cs_s;
            ft_pwrsav          <= !suspend;
            if (cs_s) begin
                state        <= ST_IDLE;
                ft_miso      <= 1'b1;
                ft_miosi_oe  <= 1'b0;
                ft_miosi_out <= BUS_IDLE;
            end else begin
                unique case (state)
                    // cs already low without a falling edge means we came out of
                    // reset mid-transaction: sit out the rest of it.
                    ST_IDLE: state <= cs_s_d ? ST_COMMAND : ST_DONE;
                    ST_COMMAND: if (tick_p1) begin
                        cmd     <= miosi_p1;
                        ft_miso <= !cmd_ack(miosi_p1, rx_space || rx_local_pop,
                                            tx_avail || tx_local_push);
                        state   <= ST_STATUS;
                    end
                    ST_STATUS: if (tick_p1) begin
                        if (ft_miso) begin
                            state <= ST_DONE;
                        end else begin
                            state   <= ST_DATA;
                            ft_miso <= 1'b0;
                            case (cmd)
                                CMD_READ: begin
                                    ft_miosi_out <= tx_head;
                                    ft_miosi_oe  <= 1'b1;
                                end
                                CMD_MODEM_RD: begin
                                    ft_miosi_out <= modem_status_in;
                                    ft_miosi_oe  <= 1'b1;
                                end
                                CMD_FLUSH: flush <= 1'b1;
                                default:   ft_miosi_oe <= 1'b0;
                            endcase
                        end
                    end
                    ST_DATA: if (tick_p1) begin
                        if (ft_miso) begin
                            state        <= ST_DONE;
                            ft_miosi_oe  <= 1'b0;
                            ft_miosi_out <= BUS_IDLE;
                        end else begin
                            case (cmd)
                                CMD_WRITE: ft_miso <= rx_full_after;
                                CMD_READ: begin
                                    if (tx_more) begin
                                        ft_miosi_out <= tx_head;
                                    end else begin
                                        ft_miso      <= 1'b1;
                                        ft_miosi_oe  <= 1'b0;
                                        ft_miosi_out <= BUS_IDLE;
                                    end
                                end
                                CMD_MODEM_WR: begin
                                    modem_status_out   <= miosi_p1;
                                    modem_status_write <= 1'b1;
                                    ft_miso            <= 1'b1;
                                end
                                default: begin
                                    ft_miso      <= 1'b1;
                                    ft_miosi_oe  <= 1'b0;
                                    ft_miosi_out <= BUS_IDLE;
                                end
                            endcase
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/ft1248_responder.md
# ft1248_responder

Synthesizable FT1248 slave: the device end of the FT1248 half-duplex link, answering the same five commands the FPGA-side USB master issues. It replaces the FTDI bridge in system-level simulation and in loopback builds, so the USB master can be exercised in closed loop. It buffers master-written bytes toward a local consumer and serves master reads from a local producer.

## Interface
Parameters:
- FIFO_DEPTH, 16, entries per direction; power of two, ≥ 2
- SYNC_STAGES, 2, synchronizer flops on ft_clk, ft_cs and ft_miosi_in

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- ft_clk  in  1  FT1248 clock from master
- ft_cs  in  1  chip select, active-low
- ft_miso  out  1  status/ack; 0 = ack/continue, 1 = nack/stop
- ft_miosi_in  in  8  bus value driven by master
- ft_miosi_out  out  8  bus value driven by responder
- ft_miosi_oe  out  1  responder drives bus
- ft_pwrsav  out  1  registered !suspend
- suspend  in  1  emulate USB suspend
- rx_valid / rx_data[7:0] out, rx_ready in: bytes written by master
- tx_valid / tx_data[7:0] in, tx_ready out: bytes for master to read
- modem_status_in  in  8  byte returned for command 0x20
- modem_status_out  out  8  last byte written by command 0x60
- modem_status_write  out  1  one-cycle pulse when modem_status_out updates
- flush  out  1  one-cycle pulse on acked command 0x08
- busy  out  1  ft_cs (synchronized) low

## Operation
- Inputs pass through SYNC_STAGES flops; a rising edge of synced ft_clk is a "tick". Data is sampled from synced ft_miosi_in at the tick.
- Outputs for phase k+1 are registered on the cycle after the tick of phase k.
- States: IDLE, COMMAND, STATUS, DATA, DONE.
- IDLE: miso=1, oe=0, miosi_out=0xFF. Synced cs falling → COMMAND.
- COMMAND tick: latch cmd. Ack rules:
  - 0x00 (master write): ack if rx FIFO not full.
  - 0x40 (master read): ack if tx FIFO not empty.
  - 0x20, 0x60, 0x08: always ack.
  - Any other byte: nack.
  - Drive miso=!ack, then → STATUS.
- STATUS tick: miso=1 → DONE. Otherwise → DATA and present beat 0:
  - 0x40: miosi_out = tx head, oe=1, miso=0.
  - 0x20: miosi_out = modem_status_in, oe=1, miso=0.
  - 0x00 / 0x60: oe=0, miso=0.
  - 0x08: pulse flush, miso=0.
- DATA tick with miso=0 completes a beat:
  - 0x00: push miosi_in to rx FIFO; next miso = full after push.
  - 0x40: pop tx FIFO; if not empty after pop, present new head with miso=0, else miso=1.
  - 0x60: modem_status_out ← miosi_in, pulse modem_status_write, miso=1.
  - 0x20 / 0x08: miso=1.
- DATA tick with miso=1: no transfer, → DONE (oe=0, miso=1).
- Synced cs rising in any state → IDLE. Already-completed beats stand; no partial byte is ever pushed.

## Timing
- Reset values: miso=1, miosi_out=0xFF, oe=0, ft_pwrsav=1, modem_status_out=0x00, pulses=0, busy=0, rx_valid=0, tx_ready=1 (both FIFOs empty). Reset clears cmd and state.
- If reset releases with cs low: go to DONE and ignore ticks until cs high.
- ft_clk high ≥ 2 clk, low ≥ 2 clk, period ≥ 4 clk. cs setup to first tick ≥ SYNC_STAGES+1 clk.
- Pin-to-output latency: SYNC_STAGES+2 clk after ft_clk rise. This is required to be ≤ one ft_clk period.
- FIFOs: first-word fall-through; local push/pop and protocol push/pop in the same cycle are both honored. Full/empty flags are the values seen at the tick cycle.
- Ack/continue decisions use FIFO state at the tick cycle, including a same-cycle local push or pop.

## Structure
- ft1248_pkg holds the e_cmd enum (0x00, 0x40, 0x20, 0x60, 0x08), shared with the USB master, and the e_state enum.
- Sub-module ft1248_responder_fifo: sync FIFO, FIFO_DEPTH × 8, valid/ready on both sides, full/empty flags. One instance per direction.

## Test plan
- Master write of 5 bytes 0x11..0x15 into an empty rx FIFO → miso acks every beat; rx_data emits 0x11..0x15 in order; no extra byte.
- Master write while rx FIFO holds FIFO_DEPTH-2 bytes → 2 bytes accepted, miso=1 on the third beat, → DONE; the next write command is nacked at status.
- tx FIFO loaded with 0xA0,0xA1,0xA2; master read → master receives 0xA0..0xA2, miso=1 after the last byte; read with empty FIFO → nack at status.
- Command 0x60 with data 0x20 → modem_status_out=0x20, one pulse. Command 0x20 with modem_status_in=0x01 → master reads 0x01. Command 0x08 → exactly one flush pulse.
- Unknown command 0x55 → nack; state, FIFOs and outputs unchanged.
- cs raised mid-read after 2 of 4 bytes → exactly 2 pops, → IDLE. reset asserted mid-write with cs low → all outputs at reset values; responder stays in DONE until cs high, then the next transaction completes normally.
